// File: rtl/regfile_arb_pkg.sv
// Shared types for the two-requester register-file arbiter.
package regfile_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Request captured at grant time and replayed to the register file in ISSUE.
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a single priority pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  input  logic       i_last_id,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  // Pointer hands priority to the requester that did not just finish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   r_ptr <= 1'b0;
    else if (i_adv) r_ptr <= ~i_last_id;
  end

  // Pointer only matters under contention; a lone requester always wins.
  always_comb begin
    o_gnt = i_req;
    if (&i_req) o_gnt = r_ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto one register-file port, one transaction in flight.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  input  logic              rsp1_ready,
  output logic              rf_write_enable,
  output logic              rf_read_enable,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_data,
  input  logic              rf_ready,
  output logic              busy
);

  state_t            r_state;
  req_t              r_req;
  logic              r_gnt_id;
  logic [1:0]        r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;

  logic [1:0] w_gnt;
  logic [1:0] w_gnt_ok;
  logic       w_arb_en;
  logic       w_strobe;
  logic       w_rsp_take;
  req_t       w_new_req;

  // Arbitration is only live in IDLE with the register file ready; reset masks it.
  assign w_arb_en   = reset_n && (r_state == ST_IDLE) && rf_ready;
  assign w_gnt_ok   = w_gnt & {2{w_arb_en}};
  assign w_strobe   = (r_state == ST_ISSUE) && rf_ready;
  assign w_rsp_take = (r_state == ST_RESP) && (r_gnt_id ? rsp1_ready : rsp0_ready);
  assign w_new_req  = w_gnt[1] ? '{req1_write, req1_addr, req1_wdata}
                               : '{req0_write, req0_addr, req0_wdata};

  rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     ({req1_valid, req0_valid}),
    .i_adv     (w_rsp_take),
    .i_last_id (r_gnt_id),
    .o_gnt     (w_gnt)
  );

  assign req0_ready = w_gnt_ok[0];
  assign req1_ready = w_gnt_ok[1];

  // Register-file port is quiet except in the single strobe cycle.
  assign rf_write_enable = w_strobe && r_req.write;
  assign rf_read_enable  = w_strobe && !r_req.write;
  assign rf_address      = w_strobe ? r_req.addr : '0;
  assign rf_write_data   = rf_write_enable ? r_req.wdata : '0;

  assign rsp0_valid = r_rsp_valid[0];
  assign rsp1_valid = r_rsp_valid[1];
  assign rsp0_rdata = r_rsp_valid[0] ? r_rsp_data : '0;
  assign rsp1_rdata = r_rsp_valid[1] ? r_rsp_data : '0;
  assign busy       = (r_state != ST_IDLE);

  // Transaction FSM: grant/latch, strobe/capture, hold response until consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_gnt_id    <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt_ok) begin
            r_req    <= w_new_req;
            r_gnt_id <= w_gnt[1];
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (rf_ready) begin
            r_rsp_data            <= r_req.write ? '0 : rf_read_data;
            r_rsp_valid[r_gnt_id] <= 1'b1;
            r_state               <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_rsp_take) begin
            r_rsp_valid <= 2'b00;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench: cycle table for the basic flows plus hand sequences for corner cases.
module tb_regfile_arbiter;

  typedef struct packed {
    logic [1:0]  v;
    logic [1:0]  w;
    logic [1:0]  a0;
    logic [31:0] d0;
    logic [1:0]  a1;
    logic [31:0] d1;
    logic [1:0]  rr;
    logic        rfr;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic [1:0]  qr;
    logic [1:0]  sv;
    logic [31:0] s0d;
    logic [31:0] s1d;
    logic        we;
    logic        re;
    logic [1:0]  ad;
    logic [31:0] wd;
    logic        bsy;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk;
  logic reset_n;
  in_t  drv;
  out_t act;
  int   total;
  int   bad;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata, rf_write_data;
  logic        rf_write_enable, rf_read_enable, busy;
  logic [1:0]  rf_address;

  regfile_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req0_valid      (drv.v[0]),
    .req0_write      (drv.w[0]),
    .req0_addr       (drv.a0),
    .req0_wdata      (drv.d0),
    .req0_ready      (req0_ready),
    .rsp0_valid      (rsp0_valid),
    .rsp0_rdata      (rsp0_rdata),
    .rsp0_ready      (drv.rr[0]),
    .req1_valid      (drv.v[1]),
    .req1_write      (drv.w[1]),
    .req1_addr       (drv.a1),
    .req1_wdata      (drv.d1),
    .req1_ready      (req1_ready),
    .rsp1_valid      (rsp1_valid),
    .rsp1_rdata      (rsp1_rdata),
    .rsp1_ready      (drv.rr[1]),
    .rf_write_enable (rf_write_enable),
    .rf_read_enable  (rf_read_enable),
    .rf_address      (rf_address),
    .rf_write_data   (rf_write_data),
    .rf_read_data    (drv.rd),
    .rf_ready        (drv.rfr),
    .busy            (busy)
  );

  assign act = {req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp0_rdata, rsp1_rdata,
                rf_write_enable, rf_read_enable, rf_address, rf_write_data, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input out_t e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, e);
    end
  endtask

  task automatic chkv(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  // Holds reset with live requests, checks every output is quiet, releases at a negedge.
  task automatic do_reset();
    reset_n = 1'b0;
    drv     = '0;
    drv.v   = 2'b11;
    drv.rfr = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("reset", '0);
    @(negedge clk);
    reset_n = 1'b1;
    drv     = '0;
  endtask

  vec_t tbl [18];

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    drv     = '0;

    //           v      w      a0    d0            a1    d1            rr     rfr   rd
    tbl[0].i  = '{2'b01, 2'b01, 2'd2, 32'hDEADBEEF, 2'd0, 32'h0,        2'b00, 1'b1, 32'h0};
    tbl[1].i  = '{2'b00, 2'b00, 2'd0, 32'h0,        2'd0, 32'h0,        2'b00, 1'b1, 32'h0};
    tbl[2].i  = '{2'b00, 2'b00, 2'd0, 32'h0,        2'd0, 32'h0,        2'b01, 1'b1, 32'h0};
    tbl[3].i  = '{2'b01, 2'b00, 2'd2, 32'h0,        2'd0, 32'h0,        2'b00, 1'b1, 32'h0};
    tbl[4].i  = '{2'b00, 2'b00, 2'd0, 32'h0,        2'd0, 32'h0,        2'b00, 1'b1, 32'hDEADBEEF};
    tbl[5].i  = '{2'b00, 2'b00, 2'd0, 32'h0,        2'd0, 32'h0,        2'b00, 1'b1, 32'h0};
    tbl[6].i  = '{2'b00, 2'b00, 2'd0, 32'h0,        2'd0, 32'h0,        2'b01, 1'b1, 32'h0};
    tbl[7].i  = '{2'b10, 2'b10, 2'd0, 32'h0,        2'd3, 32'hA5A5A5A5, 2'b00, 1'b1, 32'h0};
    tbl[8].i  = '{2'b00, 2'b00, 2'd0, 32'h0,        2'd0, 32'h0,        2'b00, 1'b1, 32'h0};
    tbl[9].i  = '{2'b00, 2'b00, 2'd0, 32'h0,        2'd0, 32'h0,        2'b10, 1'b1, 32'h0};
    tbl[10].i = '{2'b11, 2'b00, 2'd0, 32'h0,        2'd0, 32'h0,        2'b00, 1'b0, 32'h0};
    tbl[11].i = '{2'b11, 2'b00, 2'd1, 32'h0,        2'd0, 32'h0,        2'b00, 1'b1, 32'h0};
    tbl[12].i = '{2'b11, 2'b00, 2'd1, 32'h0,        2'd0, 32'h0,        2'b00, 1'b1, 32'h11};
    tbl[13].i = '{2'b11, 2'b00, 2'd1, 32'h0,        2'd0, 32'h0,        2'b01, 1'b1, 32'h0};
    tbl[14].i = '{2'b11, 2'b00, 2'd1, 32'h0,        2'd0, 32'h0,        2'b00, 1'b1, 32'h0};
    tbl[15].i = '{2'b11, 2'b00, 2'd1, 32'h0,        2'd0, 32'h0,        2'b00, 1'b1, 32'h22};
    tbl[16].i = '{2'b11, 2'b00, 2'd1, 32'h0,        2'd0, 32'h0,        2'b11, 1'b1, 32'h0};
    tbl[17].i = '{2'b11, 2'b00, 2'd1, 32'h0,        2'd0, 32'h0,        2'b00, 1'b1, 32'h0};

    //           qr     sv     s0d           s1d    we    re    ad    wd            bsy
    tbl[0].o  = '{2'b01, 2'b00, 32'h0,        32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0};
    tbl[1].o  = '{2'b00, 2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 2'd2, 32'hDEADBEEF, 1'b1};
    tbl[2].o  = '{2'b00, 2'b01, 32'h0,        32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b1};
    tbl[3].o  = '{2'b01, 2'b00, 32'h0,        32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0};
    tbl[4].o  = '{2'b00, 2'b00, 32'h0,        32'h0, 1'b0, 1'b1, 2'd2, 32'h0,        1'b1};
    tbl[5].o  = '{2'b00, 2'b01, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b1};
    tbl[6].o  = '{2'b00, 2'b01, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b1};
    tbl[7].o  = '{2'b10, 2'b00, 32'h0,        32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0};
    tbl[8].o  = '{2'b00, 2'b00, 32'h0,        32'h0, 1'b1, 1'b0, 2'd3, 32'hA5A5A5A5, 1'b1};
    tbl[9].o  = '{2'b00, 2'b10, 32'h0,        32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b1};
    tbl[10].o = '{2'b00, 2'b00, 32'h0,        32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0};
    tbl[11].o = '{2'b01, 2'b00, 32'h0,        32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0};
    tbl[12].o = '{2'b00, 2'b00, 32'h0,        32'h0, 1'b0, 1'b1, 2'd1, 32'h0,        1'b1};
    tbl[13].o = '{2'b00, 2'b01, 32'h11,       32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b1};
    tbl[14].o = '{2'b10, 2'b00, 32'h0,        32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0};
    tbl[15].o = '{2'b00, 2'b00, 32'h0,        32'h0, 1'b0, 1'b1, 2'd0, 32'h0,        1'b1};
    tbl[16].o = '{2'b00, 2'b10, 32'h0,        32'h22, 1'b0, 1'b0, 2'd0, 32'h0,       1'b1};
    tbl[17].o = '{2'b01, 2'b00, 32'h0,        32'h0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0};

    // Table: one row per cycle, inputs applied at negedge, outputs checked before posedge.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      drv = tbl[k].i;
      #1 chk($sformatf("vec%0d", k), tbl[k].o);
      @(negedge clk);
    end

    // Contention from reset: grants must alternate starting with requester 0.
    do_reset();
    drv.v = 2'b11; drv.rr = 2'b11; drv.rfr = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      int n;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 6) begin
        @(negedge clk); #1; n++;
      end
      if (n == 6) chkv($sformatf("rr_timeout%0d", k), 64'd0, 64'd1);
      else chkv($sformatf("rr_grant%0d", k), {62'd0, req1_ready, req0_ready},
                (k % 2 == 1) ? 64'd2 : 64'd1);
      @(negedge clk); #1;
    end

    // Backpressure: response held, data stable, no new grants.
    @(negedge clk);
    do_reset();
    drv.v = 2'b10; drv.a1 = 2'd1; drv.rfr = 1'b1;
    #1 chkv("bp_acc", {63'd0, req1_ready}, 64'd1);
    @(negedge clk);
    drv = '0; drv.rfr = 1'b1; drv.rd = 32'hCAFE0001;
    #1 chkv("bp_strobe", {62'd0, rf_read_enable, rf_address == 2'd1}, 64'd3);
    @(negedge clk);
    drv.rd = 32'h0; drv.v = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1 chkv($sformatf("bp_hold%0d", k),
              {28'd0, rsp1_valid, rsp1_rdata, req0_ready, req1_ready, busy},
              {28'd0, 1'b1, 32'hCAFE0001, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
    end
    drv.v = 2'b00; drv.rr = 2'b10;
    @(negedge clk);
    drv.rr = 2'b00;
    #1 chkv("bp_done", {62'd0, rsp1_valid, busy}, 64'd0);
    @(negedge clk);

    // rf_ready low during ISSUE: strobe waits, then response the following cycle.
    do_reset();
    drv.v = 2'b01; drv.w = 2'b01; drv.a0 = 2'd1; drv.d0 = 32'h55; drv.rfr = 1'b1;
    #1 chkv("rfr_acc", {63'd0, req0_ready}, 64'd1);
    @(negedge clk);
    drv = '0;
    for (int k = 0; k < 3; k++) begin
      #1 chkv($sformatf("rfr_low%0d", k),
              {28'd0, rf_write_enable, rf_read_enable, rf_address, rf_write_data, busy, rsp0_valid},
              {28'd0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0});
      @(negedge clk);
    end
    drv.rfr = 1'b1;
    #1 chkv("rfr_back", {28'd0, rf_write_enable, rf_read_enable, rf_address, rf_write_data},
            {28'd0, 1'b1, 1'b0, 2'd1, 32'h55});
    @(negedge clk);
    #1 chkv("rfr_rsp", {31'd0, rsp0_valid, rsp0_rdata}, {31'd0, 1'b1, 32'h0});
    drv.rr = 2'b01;
    @(negedge clk);
    drv.rr = 2'b00;

    // Reset in RESP: pointer moved to 1 by a prior write, then a read is dropped.
    do_reset();
    drv.v = 2'b01; drv.w = 2'b01; drv.d0 = 32'h1; drv.rfr = 1'b1;
    @(negedge clk);
    drv = '0; drv.rfr = 1'b1;
    @(negedge clk);
    drv.rr = 2'b01;
    @(negedge clk);
    drv = '0; drv.v = 2'b01; drv.rfr = 1'b1;
    @(negedge clk);
    drv = '0; drv.rfr = 1'b1; drv.rd = 32'h12345678;
    @(negedge clk);
    drv.rd = 32'h0;
    #1 chkv("mid_rsp", {31'd0, rsp0_valid, rsp0_rdata}, {31'd0, 1'b1, 32'h12345678});
    #2 reset_n = 1'b0;
    #1 chkv("mid_drop", {28'd0, rsp0_valid, rsp0_rdata, busy, rf_write_enable, rf_read_enable},
            64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chkv($sformatf("mid_norsp%0d", k), {61'd0, rsp0_valid, rsp1_valid, busy}, 64'd0);
      @(negedge clk);
    end
    drv.v = 2'b11;
    #1 chkv("mid_ptr", {62'd0, req1_ready, req0_ready}, 64'd1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter DATA_W, 32, data width of the register file port.
REQ-002 Parameter ADDR_W, 2, register address width (4 registers).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  reset is asynchronous and active-low.
REQ-005 reqN_valid  input  1  requester N (N=0,1) has a request pending.
REQ-006 reqN_write  input  1  1=write, 0=read; qualified by reqN_valid.
REQ-007 reqN_addr  input  ADDR_W  target register.
REQ-008 reqN_wdata  input  DATA_W  write data.
REQ-009 reqN_ready  output  1  request accepted this cycle (valid&&ready).
REQ-010 rspN_valid  output  1  response available to requester N.
REQ-011 rspN_rdata  output  DATA_W  read data; 0 for write responses.
REQ-012 rspN_ready  input  1  requester N consumes response.
REQ-013 rf_write_enable, rf_read_enable  output  1 each  register-file strobes.
REQ-014 rf_address  output  ADDR_W; rf_write_data  output  DATA_W.
REQ-015 rf_read_data  input  DATA_W  combinational read data from register file.
REQ-016 rf_ready  input  1  register file out of reset and accepting accesses.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, RESP; exactly one transaction in flight.
REQ-019 IDLE: if rf_ready=1 and any reqN_valid=1, assert reqN_ready combinationally for the granted requester only, latch write/addr/wdata and grant id, go to ISSUE.
REQ-020 IDLE with rf_ready=0: no reqN_ready asserted, stay IDLE.
REQ-021 Arbitration round-robin: priority pointer selects winner when both valid; a lone valid requester wins regardless of pointer.
REQ-022 Pointer moves to the other requester when a transaction leaves RESP; pointer reset value selects requester 0.
REQ-023 ISSUE: drive rf_address/rf_write_data from latched request, assert rf_write_enable (write) or rf_read_enable (read) for exactly one cycle when rf_ready=1; for reads capture rf_read_data into the response register at that edge; go to RESP.
REQ-024 ISSUE with rf_ready=0: strobes low, remain in ISSUE, retry when rf_ready returns.
REQ-025 RESP: assert rspN_valid for the granted requester only; rspN_rdata stable while valid; on rspN_ready=1 deassert and go to IDLE.
REQ-026 Latency: accept at cycle T, rf strobe at T+1, rspN_valid at T+2; minimum 3 cycles per transaction.
REQ-027 A new request is never accepted in the same cycle a response is consumed.
REQ-028 Write response carries rspN_rdata=0.
REQ-029 All rf_* outputs 0 outside the ISSUE strobe cycle.

Reset
REQ-030 reset_n=0 asynchronously forces IDLE, pointer=0, all outputs 0, latched request and response data 0.
REQ-031 Reset mid-transaction drops the in-flight request with no rf strobe and no response.
REQ-032 Reset deassertion is synchronised by the integrator; block leaves IDLE no earlier than the first edge with reset_n=1.

Structure
REQ-033 Package regfile_arb_pkg holds the state enum, DATA_W/ADDR_W defaults and the request struct (write, addr, wdata).
REQ-034 Sub-module rr_arb2 (2-way round-robin grant, pointer register) instantiated once; remaining logic in regfile_arbiter.

Verification
REQ-035 Write then read: req0 write addr 2 data 0xDEADBEEF, then req0 read addr 2 -> rf_write_enable at T+1 with addr 2, read response rsp0_rdata=0xDEADBEEF at T+2 of the read.
REQ-036 Contention: both valid from reset, four back-to-back requests each -> grants alternate 0,1,0,1,...; first grant to req0.
REQ-037 Backpressure: rsp1_ready held 0 for 5 cycles -> rsp1_valid and data stable, reqN_ready stays 0, busy=1 throughout.
REQ-038 rf_ready low: rf_ready=0 during ISSUE for 3 cycles -> no strobe, strobe issued on first cycle rf_ready=1, response follows next cycle.
REQ-039 Reset mid-op: reset_n pulsed low in RESP with read of 0x12345678 pending -> rsp valid drops immediately, state IDLE, pointer 0, no further response.
REQ-040 Write response: req1 write addr 3 0xA5A5A5A5 -> rsp1_valid with rsp1_rdata=0.
